// File: rtl/ex_mdu_iter_if.sv
// Handshake and operand bundle between the Execute stage and the iterative MDU.
interface ex_mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            s_start_i;
  logic            s_flush_i;
  logic            s_stall_i;
  logic [2:0]      s_function_i;
  logic [XLEN-1:0] s_operand1_i;
  logic [XLEN-1:0] s_operand2_i;
  logic            s_busy_o;
  logic            s_finished_o;
  logic [XLEN-1:0] s_result_o;

  modport master (
    output s_start_i, s_flush_i, s_stall_i, s_function_i, s_operand1_i, s_operand2_i,
    input  s_busy_o, s_finished_o, s_result_o
  );

  modport slave (
    input  s_start_i, s_flush_i, s_stall_i, s_function_i, s_operand1_i, s_operand2_i,
    output s_busy_o, s_finished_o, s_result_o
  );
endinterface

// File: rtl/ex_mdu_iter.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring
// divide on operand magnitudes, BPC bits per cycle; sign fix-up is folded
// into the result register load so the output is purely registered.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module ex_mdu_iter #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input logic         s_clk_i,
  input logic         s_reset_i,
  ex_mdu_iter_if.slave mdu
);
  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N);

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3,
                         F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  generate
    if ((XLEN % 2) != 0 || XLEN < 8 || !(BPC == 1 || BPC == 2 || BPC == 4) || (XLEN % BPC) != 0)
      begin : g_bad_params
        $error("ex_mdu_iter: unsupported XLEN/BPC combination");
      end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2*XLEN-1:0] acc;    // mul: {partial sum, multiplier}; div: low half is quotient
  logic [XLEN-1:0]   rem;    // divide partial remainder (always < divisor)
  logic [XLEN-1:0]   opb;    // multiplicand / divisor magnitude
  logic [2:0]        func_q;
  logic              neg_p;  // negate product / quotient
  logic              neg_r;  // negate remainder
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   res_q;

  // entry decode: signedness, magnitudes and the single-cycle special cases
  logic            sgn_a, sgn_b, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;
  logic [2:0]      fn;
  logic [XLEN-1:0] op1, op2;

  assign fn  = mdu.s_function_i;
  assign op1 = mdu.s_operand1_i;
  assign op2 = mdu.s_operand2_i;

  // operand conditioning and special-case result for the IDLE start
  always_comb begin
    sgn_a    = (fn == F_MULH || fn == F_MULHSU || fn == F_DIV || fn == F_REM) && op1[XLEN-1];
    sgn_b    = (fn == F_MULH || fn == F_DIV || fn == F_REM) && op2[XLEN-1];
    mag_a    = sgn_a ? -op1 : op1;
    mag_b    = sgn_b ? -op2 : op2;
    div_zero = (op2 == '0);
    div_ovf  = (fn == F_DIV || fn == F_REM) && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    special  = fn[2] && (div_zero || div_ovf);
    if (fn[1]) spec_res = div_zero ? op1 : '0;
    else       spec_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // one iteration's worth of BPC multiply and divide steps, plus final result
  logic [2*XLEN-1:0] m_acc, prod;
  logic [XLEN:0]     m_sum, d_sh, d_trial;
  logic [XLEN-1:0]   d_rem, d_quo, quo, rmd, calc_res;

  always_comb begin
    m_acc = acc;
    m_sum = '0;
    for (int i = 0; i < BPC; i++) begin
      m_sum = {1'b0, m_acc[2*XLEN-1:XLEN]} + (m_acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      m_acc = {m_sum, m_acc[XLEN-1:1]};
    end
    d_rem   = rem;
    d_quo   = acc[XLEN-1:0];
    d_sh    = '0;
    d_trial = '0;
    for (int i = 0; i < BPC; i++) begin
      d_sh    = {d_rem, d_quo[XLEN-1]};
      d_trial = d_sh - {1'b0, opb};
      d_quo   = {d_quo[XLEN-2:0], ~d_trial[XLEN]};
      d_rem   = d_trial[XLEN] ? d_sh[XLEN-1:0] : d_trial[XLEN-1:0];
    end
    prod = neg_p ? -m_acc : m_acc;
    quo  = neg_p ? -d_quo : d_quo;
    rmd  = neg_r ? -d_rem : d_rem;
    case (func_q)
      F_MUL:                    calc_res = prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: calc_res = prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:            calc_res = quo;
      default:                  calc_res = rmd;
    endcase
  end

  // state register
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // next-state logic; flush dominates everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mdu.s_start_i) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == CW'(N-1)) state_nxt = DONE;
      DONE: if (!mdu.s_stall_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (mdu.s_flush_i) state_nxt = IDLE;
  end

  // datapath registers: operand latch, iteration, result load/clear
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      acc <= '0; rem <= '0; opb <= '0; func_q <= '0;
      neg_p <= 1'b0; neg_r <= 1'b0; cnt <= '0; res_q <= '0;
    end else if (mdu.s_flush_i) begin
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (mdu.s_start_i) begin
          if (special) res_q <= spec_res;
          else begin
            acc    <= {{XLEN{1'b0}}, mag_a};
            rem    <= '0;
            opb    <= mag_b;
            func_q <= fn;
            neg_p  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc <= func_q[2] ? {acc[2*XLEN-1:XLEN], d_quo} : m_acc;
          rem <= d_rem;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-1)) res_q <= calc_res;
        end
        DONE: if (!mdu.s_stall_i) res_q <= '0;
        default: ;
      endcase
    end
  end

  assign mdu.s_busy_o     = (state == CALC);
  assign mdu.s_finished_o = (state == DONE);
  assign mdu.s_result_o   = res_q;
endmodule

// File: tb/tb_ex_mdu_iter.sv
// Bench for ex_mdu_iter: a BPC=1 and a BPC=4 instance share stimulus,
// one is started at a time; results come from a plain-arithmetic model.
module tb_ex_mdu_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mdu_iter_if #(.XLEN(32)) b1();
  ex_mdu_iter_if #(.XLEN(32)) b4();

  ex_mdu_iter #(.XLEN(32), .BPC(1)) dut1 (.s_clk_i(clk), .s_reset_i(rst), .mdu(b1.slave));
  ex_mdu_iter #(.XLEN(32), .BPC(4)) dut4 (.s_clk_i(clk), .s_reset_i(rst), .mdu(b4.slave));

  logic        sel, start, flush, stall;
  logic [2:0]  func;
  logic [31:0] opa, opb;

  assign b1.s_start_i = start & ~sel;
  assign b4.s_start_i = start & sel;
  assign b1.s_flush_i = flush;   assign b4.s_flush_i = flush;
  assign b1.s_stall_i = stall;   assign b4.s_stall_i = stall;
  assign b1.s_function_i = func; assign b4.s_function_i = func;
  assign b1.s_operand1_i = opa;  assign b4.s_operand1_i = opa;
  assign b1.s_operand2_i = opb;  assign b4.s_operand2_i = opb;

  logic        fin, busy;
  logic [31:0] res;
  always_comb begin
    fin  = sel ? b4.s_finished_o : b1.s_finished_o;
    busy = sel ? b4.s_busy_o     : b1.s_busy_o;
    res  = sel ? b4.s_result_o   : b1.s_result_o;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // one cycle of start on the selected instance; leaves operands stable
  task automatic issue(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    sel = s; func = f; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int stall_cyc, input string tag);
    logic [31:0] exp = ref_model(f, a, b);
    int n   = s ? 8 : 32;
    int lat = 1;
    int bc  = 0;
    bit sp  = is_special(f, a, b);
    stall = (stall_cyc > 0);
    issue(s, f, a, b);
    while (!fin && lat < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " finished"}, 32'(fin), 32'd1);
    chk({tag, " result"}, res, exp);
    chk({tag, " latency"}, 32'(lat), sp ? 32'd1 : 32'(n + 1));
    chk({tag, " busy cycles"}, 32'(bc), sp ? 32'd0 : 32'(n));
    for (int k = 0; k < stall_cyc; k++) begin
      @(posedge clk); #1;
      chk({tag, " stall hold"}, {31'b0, fin}, 32'd1);
      chk({tag, " stall result"}, res, exp);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle finished"}, 32'(fin), 32'd0);
    chk({tag, " idle result"}, res, 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start = 1'b0; flush = 1'b0; stall = 1'b0;
    func = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy1", 32'(b1.s_busy_o), 0);
    chk("reset fin1", 32'(b1.s_finished_o), 0);
    chk("reset res1", b1.s_result_o, 0);
    chk("reset fin4", 32'(b4.s_finished_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    run_op(1'b0, 3'd0, 32'h7, 32'hFFFF_FFFD, 0, "mul");
    run_op(1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run_op(1'b0, 3'd3, 32'h8000_0000, 32'h8000_0000, 0, "mulhu");
    run_op(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h2, 0, "mulhsu");
    run_op(1'b0, 3'd4, 32'd100, 32'd0, 0, "div by zero");
    run_op(1'b0, 3'd7, 32'd100, 32'd0, 0, "remu by zero");
    run_op(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
    run_op(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem ovf");
    run_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
    run_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem -7/2");
    run_op(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div4 -7/2");
    run_op(1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh4");

    // flush at iteration 10, then full-latency DIVU
    issue(1'b0, 3'd5, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    chk("pre-flush busy", 32'(busy), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 0);
    chk("flush fin", 32'(fin), 0);
    chk("flush res", res, 0);
    run_op(1'b0, 3'd5, 32'd100, 32'd7, 0, "divu after flush");

    // flush and start together: nothing starts
    sel = 1'b0; func = 3'd0; opa = 32'd3; opb = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", 32'(busy), 0);
    chk("flush+start fin", 32'(fin), 0);

    // stall in DONE for 5 cycles
    run_op(1'b0, 3'd0, 32'd12345, 32'd678, 5, "stall mul");
    run_op(1'b1, 3'd6, 32'd100, 32'd0, 5, "stall rem0");

    // asynchronous reset mid-CALC
    issue(1'b0, 3'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy), 0);
    chk("async rst fin", 32'(fin), 0);
    chk("async rst res", res, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // randomized operations on both instances
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rf = 3'($urandom_range(0, 7));
      logic [31:0] ra = $urandom;
      logic [31:0] rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(1'(i % 2), rf, ra, rb, 0, $sformatf("rand%0d f%0d", i, rf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ex_mdu_iter.md
# ex_mdu_iter

Parametrised iterative multiply/divide unit for the Execute stage. It replaces the single-radix MDU path behind the executor's `s_finished_o` handshake. Width, radix (bits retired per cycle) and the RV32M function set are configurable. A multi-cycle operation raises a pipeline bubble until the result is ready. Divide-by-zero and signed overflow resolve in a single cycle. Flush aborts any operation in progress.

## Interface
- `XLEN`, default 32: operand/result width; must be even and ≥ 8.
- `BPC`, default 1: bits retired per iteration; 1, 2 or 4; must divide `XLEN`.
- `s_clk_i`, input, 1: clock.
- `s_reset_i`, input, 1: asynchronous, active-high reset.
- `s_start_i`, input, 1: MDU instruction present in EX; sampled only in IDLE.
- `s_flush_i`, input, 1: abort; dominates all other inputs.
- `s_stall_i`, input, 1: downstream (MA) stall; holds a finished result.
- `s_function_i`, input, 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `s_operand1_i`, input, XLEN: rs1 value / dividend; stable while busy.
- `s_operand2_i`, input, XLEN: rs2 value / divisor; stable while busy.
- `s_busy_o`, output, 1: state is CALC.
- `s_finished_o`, output, 1: result valid (state DONE).
- `s_result_o`, output, XLEN: result; 0 unless `s_finished_o` is 1.

## Operation
- FSM has three states: IDLE, CALC, DONE. On reset: IDLE, counter 0, accumulators 0, all outputs 0.
- **IDLE**
  - `s_start_i & ~s_flush_i` with a special case goes to DONE.
  - `s_start_i & ~s_flush_i` otherwise latches operands and goes to CALC. Latching means magnitudes for signed operands, the sign-fix flag and the function.
  - Special cases:
    - DIV/DIVU with divisor 0: quotient all-ones. REM/REMU with divisor 0: remainder = dividend.
    - DIV with `INT_MIN / -1`: quotient `INT_MIN`. REM with the same operands: remainder 0.
- **CALC**
  - Each cycle retires `BPC` bits.
  - Multiply: shift-add on a 2·XLEN accumulator; adds `BPC` partial products per cycle.
  - Divide: restoring, `BPC` quotient bits per cycle; XLEN+1-bit partial remainder.
  - The counter counts `XLEN/BPC` iterations, then the FSM goes to DONE.
- **Signedness**
  - MULH: both operands signed. MULHSU: only operand1 signed. DIV/REM: both signed.
  - Quotient sign = XOR of the operand signs. Remainder sign = dividend sign.
  - Negation is applied on entry to DONE, so `s_result_o` is purely registered.
- **Result selection**
  - MUL: low XLEN bits. MULH*: high XLEN bits. DIV*: quotient. REM*: remainder.
- **DONE**
  - `s_finished_o` = 1.
  - Stays in DONE while `s_stall_i`.
  - Goes to IDLE on `~s_stall_i`. A new start is not accepted in this same cycle.
- **Flush:** from any state, go to IDLE next edge. `s_finished_o` and `s_busy_o` drop to 0 and the result register clears.
- **Reset mid-operation:** immediate return to the reset values (asynchronous).

## Timing
- N = `XLEN/BPC`.
- Normal operation: start sampled at edge 0; CALC for edges 1..N; `s_finished_o` is high in the cycle after edge N. Latency from the start cycle to the finished cycle is N+1 cycles (33 for XLEN=32, BPC=1; 9 for BPC=4).
- Special case: `s_finished_o` is high in the cycle after the start cycle (latency 1).
- Minimum spacing between two starts: the finished cycle plus one IDLE cycle.
- The bubble condition upstream is `start & ~finished`. The unit guarantees `s_finished_o` stays high until the edge on which `~s_stall_i` is sampled.
- Flush and start in the same IDLE cycle: flush wins; no operation starts.
- Flush in the finished cycle: the result is discarded.

## Test plan
- **MUL:** XLEN=32, BPC=1, `0x00000007 × 0xFFFFFFFD` → `s_result_o` = `0xFFFFFFEB`; `s_finished_o` rises exactly 33 cycles after the start cycle; `s_busy_o` is high for 32 cycles.
- **MULH vs MULHU:** `0x80000000 × 0x80000000` → MULH gives `0x40000000`; MULHU gives `0x40000000`. MULHSU with `0xFFFFFFFF × 0x00000002` gives `0xFFFFFFFF`.
- **Special-case divides (latency 1, no CALC cycle):**
  - DIV `0x00000064 / 0` → `0xFFFFFFFF`.
  - REMU `0x00000064 / 0` → `0x00000064`.
  - DIV `0x80000000 / 0xFFFFFFFF` → `0x80000000`.
  - REM with the same operands → `0`.
- **Signed division:** DIV `-7 / 2` → `0xFFFFFFFD`; REM `-7 / 2` → `0xFFFFFFFF`. With BPC=4, `s_finished_o` rises 9 cycles after start.
- **Flush mid-CALC:** flush at iteration 10 → IDLE next cycle with `s_result_o` = 0. A following DIVU `100 / 7` → 14 with full latency.
- **Stall and reset:**
  - Hold `s_stall_i` high for 5 cycles in DONE → result stable for all 5 cycles; IDLE the cycle after stall drops.
  - Assert `s_reset_i` asynchronously mid-CALC → all outputs 0 immediately.
